// File: rtl/lb_pair_reader.sv
// Read-side engine for the bilinear line buffer: streams adjacent pixel pairs from one cached row.
// Optional LB_PAIR_READER_STALL_CNT_EN adds a saturating stall_cycles counter output.
module lb_pair_reader #(
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] col_start,
    input  logic [ADDR_W-1:0] col_count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        pix0,
    output logic [7:0]        pix1,
    output logic              pix_last,
    output logic              busy,
`ifdef LB_PAIR_READER_STALL_CNT_EN
    output logic [15:0]       stall_cycles,
`endif
    output logic              done
);
    localparam int unsigned LINE_WORDS = LINE_WIDTH >> 2;
    localparam int unsigned CW         = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(LINE_WORDS - 1);
    localparam logic [CW-1:0]     LINE_END  = CW'(LINE_WIDTH);
    localparam logic [CW-1:0]     LAST_PIX  = CW'(LINE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        ph_q, ph_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0]     x_q, x_d, rem_q, rem_d;
    logic [31:0]       cur_q, cur_d;
    logic [7:0]        pix0_q, pix0_d, pix1_q, pix1_d;
    logic              pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [CW-1:0]     start_x, start_avail, start_cnt;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       cur_shift;
    logic [7:0]        ld_p0, ld_p1;
    logic              ld_cross, load;

    // Effective pair count after clipping the request to the row
    always_comb begin
        start_x     = CW'(col_start);
        start_avail = (start_x < LINE_END) ? (LINE_END - start_x) : '0;
        start_cnt   = (CW'(col_count) < start_avail) ? CW'(col_count) : start_avail;
    end

    // Pair extraction from the window {rd_data = word w+1, cur_q = word w}
    always_comb begin
        cur_shift = cur_q >> {x_q[1:0], 3'b000};
        ld_cross  = (x_q[1:0] == 2'd3);
        ld_p0     = cur_shift[7:0];
        ld_p1     = ld_cross ? rd_data[7:0] : cur_shift[15:8];
        if (x_q == LAST_PIX) begin
            ld_p1 = ld_p0;
        end
        next_addr = (rd_addr_q < LAST_WORD) ? (rd_addr_q + ADDR_W'(1)) : rd_addr_q;
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        rd_addr_d   = rd_addr_q;
        x_d         = x_q;
        rem_d       = rem_q;
        cur_d       = cur_q;
        pix0_d      = pix0_q;
        pix1_d      = pix1_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRIME;
                    ph_d    = 2'd0;
                    busy_d  = 1'b1;
                    x_d     = start_x;
                    rem_d   = start_cnt;
                    if (start_cnt != '0) begin
                        rd_addr_d = ADDR_W'(start_x >> 2);
                    end
                end
            end
            PRIME: begin
                ph_d = ph_q + 2'd1;
                if (rem_q == '0) begin
                    // Empty request still spends two cycles so done lands as for a read
                    if (ph_q != 2'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else if (ph_q == 2'd0) begin
                    rd_addr_d = next_addr;
                end else if (ph_q == 2'd1) begin
                    cur_d = rd_data;
                end else begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (pix_valid_q && pix_ready && pix_last_q) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                end else if ((!pix_valid_q || pix_ready) && (rem_q != '0)) begin
                    load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pix_valid_d = 1'b1;
            pix0_d      = ld_p0;
            pix1_d      = ld_p1;
            pix_last_d  = (rem_q == CW'(1));
            x_d         = x_q + CW'(1);
            rem_d       = rem_q - CW'(1);
            // Crossing a word: slide the window and prefetch the following word
            if (ld_cross) begin
                cur_d     = rd_data;
                rd_addr_d = next_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ph_q        <= 2'd0;
            rd_addr_q   <= '0;
            x_q         <= '0;
            rem_q       <= '0;
            cur_q       <= '0;
            pix0_q      <= '0;
            pix1_q      <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            rd_addr_q   <= rd_addr_d;
            x_q         <= x_d;
            rem_q       <= rem_d;
            cur_q       <= cur_d;
            pix0_q      <= pix0_d;
            pix1_q      <= pix1_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef LB_PAIR_READER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if (pix_valid_q && !pix_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign rd_addr   = rd_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix0      = pix0_q;
    assign pix1      = pix1_q;
    assign pix_last  = pix_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
